uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised UART transmitter. It serialises a configurable-width word LSB-first with an optional parity bit and 1 or 2 stop bits. Words are accepted over a valid/ready handshake into a one-deep holding buffer, so consecutive frames go out back-to-back with no idle gap. It sits between the TX FIFO (or a CPU register) and the pad, and supersedes the fixed 8N1 9600-baud transmitter.

Parameters:
- CLKS_PER_BIT, 10416: clock cycles per serial bit; must be >= 2.
- DATA_BITS, 8: payload bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  tx_data is valid.
- tx_data  in  DATA_BITS  word to send.
- tx_ready  out  1  holding buffer is empty; a word is accepted when tx_valid && tx_ready at a rising edge.
- tx_serial  out  1  serial line; idles high.
- tx_busy  out  1  a frame is on the line (any state except IDLE).
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (asynchronous, immediate): tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, buffer empty, bit counter=0, bit index=0.
- Reset during a frame aborts it. The line returns high immediately and any buffered word is discarded.
- Holding buffer:
  - tx_ready = !buf_valid, registered.
  - On acceptance, tx_data is copied to buf_data and buf_valid is set.
  - buf_valid clears on the edge where the shifter loads from the buffer.
  - While buf_valid=1, tx_valid is ignored and the buffer contents do not change.
  - Acceptance and load on the same edge: the buffer is refilled with the new word and buf_valid stays 1.
- States:
  - IDLE: tx_serial=1. If buf_valid, load shift register, clear buffer, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial=shift[bit_idx] for CLKS_PER_BIT cycles per bit, bit_idx 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: drives the parity bit for CLKS_PER_BIT cycles, then go to STOP. Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - On the final cycle, pulse tx_done.
    - If buf_valid, load and go directly to START (zero idle gap); else go to IDLE.
- Latency: word accepted at edge E0. IDLE loads at E1 and tx_serial goes 0 from E1.
- Frame length: exactly (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Bit counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps to 0 on every bit boundary; it never overflows.
- Stop-bit counter: separate from the bit counter, counts 0..STOP_BITS-1.
- All outputs are registered; tx_serial has no combinational path from the inputs.
- tx_busy=0 only in IDLE. During back-to-back frames tx_busy stays 1 continuously.
- tx_done rises on the edge that leaves STOP, whether the next state is IDLE or START.
- Illegal parameter values trigger an elaboration-time $error: DATA_BITS outside 5..9, STOP_BITS not 1 or 2, CLKS_PER_BIT < 2.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - parity-mode localparams (PAR_EVEN=0, PAR_ODD=1).
- One natural sub-module: uart_bit_timer, parameter CLKS_PER_BIT.
  - Inputs: clk, rst, clr.
  - Output: bit_end, a pulse on the last cycle of each bit period.
  - The FSM stays in uart_tx_param.

Test Plan:
- Defaults except CLKS_PER_BIT=16. Send 0x55, hold tx_valid one cycle -> tx_serial 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level exactly 16 cycles; tx_done pulses once at cycle 160 after E1; tx_ready=1 again at E1.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 11 bits (176 cycles).
- Back-to-back 0xA3 then 0x3C, second word presented while the first shifts -> tx_ready low after the second acceptance; second start bit begins on the edge immediately after the first frame's final stop cycle; tx_busy never drops.
- STOP_BITS=2, DATA_BITS=7, send 0x7F -> seven 1s then stop high for 32 cycles; tx_done only at the end of the second stop bit.
- Assert rst mid-DATA with a word buffered -> tx_serial=1 and tx_ready=1 immediately; no tx_done; after release the line stays idle until a new word is accepted.
- Hold tx_valid with changing tx_data while the buffer is full -> buffered value unchanged; the next frame carries the word captured at acceptance.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter: FSM state encoding
// and parity-mode selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Held at zero while i_clr is asserted.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_end = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first data, optional parity, 1 or 2 stop
// bits, with a one-deep holding buffer so frames can run back-to-back.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx_serial,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end

    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_buf_data;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_buf_valid;
    logic                 r_ready;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;

    logic w_bit_end;
    logic w_timer_clr;
    logic w_stop_last;
    logic w_load;
    logic w_accept;
    logic w_buf_parity;

    assign w_timer_clr  = (r_state == IDLE);
    assign w_stop_last  = (r_state == STOP) && w_bit_end && (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_load       = r_buf_valid && ((r_state == IDLE) || w_stop_last);
    assign w_accept     = i_tx_valid && r_ready;
    assign w_buf_parity = (^r_buf_data) ^ (PAR_MODE == PAR_ODD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_timer_clr),
        .o_bit_end(w_bit_end)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_buf_data  <= '0;
            r_shift     <= '0;
            r_buf_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_parity    <= 1'b0;
            r_serial    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Acceptance wins over the load-clear so a same-edge refill keeps the buffer full.
            if (w_accept) begin
                r_buf_data  <= i_tx_data;
                r_buf_valid <= 1'b1;
                r_ready     <= 1'b0;
            end else if (w_load) begin
                r_buf_valid <= 1'b0;
                r_ready     <= 1'b1;
            end

            if (w_load) begin
                r_shift  <= r_buf_data;
                r_parity <= w_buf_parity;
                r_state  <= START;
                r_serial <= 1'b0;
                r_busy   <= 1'b1;
                r_done   <= w_stop_last;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    START: if (w_bit_end) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_serial  <= r_shift[0];
                    end
                    DATA: if (w_bit_end) begin
                        if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                r_state  <= PARITY;
                                r_serial <= r_parity;
                            end else begin
                                r_state    <= STOP;
                                r_serial   <= 1'b1;
                                r_stop_idx <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end
                    PARITY: if (w_bit_end) begin
                        r_state    <= STOP;
                        r_serial   <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end
                    STOP: if (w_bit_end) begin
                        if (w_stop_last) begin
                            r_done   <= 1'b1;
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                            r_serial <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_tx_ready  = r_ready;
    assign o_tx_serial = r_serial;
    assign o_tx_busy   = r_busy;
    assign o_tx_done   = r_done;

endmodule
